// File: rtl/cavlc_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_bit_packer
// Description : CAVLC bitstream writer. Concatenates 1..16-bit codewords
//               (MSB first) into a 32-bit MSB-aligned accumulator and emits
//               packed 16-bit words over a valid/ready handshake. A flush
//               optionally appends an RBSP stop bit, zero-pads to a word
//               boundary and pulses flush_done_o when the stream is aligned.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   code_i[15:0]   codeword, right-justified (bits above length ignored)
//   code_len_i[4:0] codeword length; 0 = no-op, 17..31 treated as 16
//   code_valid_i   code_i/code_len_i valid
//   code_ready_o   packer accepts a code this cycle
//   flush_i        align/terminate request (honoured only while running)
//   word_out_o     packed word, first bit in bit 15
//   word_valid_o   word_out_o valid
//   word_ready_i   downstream accepts word_out_o
//   flush_done_o   one-cycle pulse, flush complete
//   total_bits_o   running count of accepted payload bits (mod 2^32)
// Configuration
//   CAVLC_PACKER_STOPBIT_EN : when defined, a single '1' stop bit is appended
//                             before zero padding on every flush.
// ============================================================================
module cavlc_bit_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] code_i,
    input  logic [4:0]  code_len_i,
    input  logic        code_valid_i,
    output logic        code_ready_o,
    input  logic        flush_i,
    output logic [15:0] word_out_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        flush_done_o,
    output logic [31:0] total_bits_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] total_q, total_d;
    logic        done_q, done_d;

    logic        w_word_valid;
    logic        w_word_xfer;
    logic        w_code_ready;
    logic        w_code_xfer;
    logic [4:0]  w_eff_len;
    logic [4:0]  w_add_len;
    logic [4:0]  w_cnt_shift;
    logic [15:0] w_mask;
    logic [15:0] w_code_m;
    logic [5:0]  w_place_sh;
    logic [31:0] w_acc_shift;
    logic [31:0] w_place;

    assign w_word_valid = cnt_q[4];
    assign w_word_xfer  = w_word_valid & word_ready_i;
    assign w_code_ready = (state_q == ST_RUN) && (!cnt_q[4] || word_ready_i);
    assign w_code_xfer  = code_valid_i & w_code_ready;

    // Lengths 16..31 all saturate to a full 16-bit codeword.
    assign w_eff_len = code_len_i[4] ? 5'd16 : code_len_i;
    assign w_add_len = w_code_xfer ? w_eff_len : 5'd0;

    // Only len==16 has bit 4 set after saturation; it keeps every bit.
    assign w_mask   = w_add_len[4] ? 16'hFFFF : ((16'd1 << w_add_len[3:0]) - 16'd1);
    assign w_code_m = code_i & w_mask;

    // Word drain happens first so the new code lands below what remains.
    assign w_acc_shift = w_word_xfer ? {acc_q[15:0], 16'h0000} : acc_q;
    assign w_cnt_shift = w_word_xfer ? (cnt_q - 5'd16) : cnt_q;

    // MSB of the code goes to bit (31 - count). A shift of 32 only occurs
    // for a zero-length code, whose masked value is already zero.
    assign w_place_sh = 6'd32 - {1'b0, w_cnt_shift} - {1'b0, w_add_len};
    assign w_place    = {16'h0000, w_code_m} << w_place_sh;

    always_comb begin
        state_d = state_q;
        acc_d   = w_acc_shift | w_place;
        cnt_d   = w_cnt_shift + w_add_len;
        total_d = total_q + {27'd0, w_add_len};
        done_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                // Full words drain through the normal path first.
                if (!cnt_q[4]) begin
`ifdef CAVLC_PACKER_STOPBIT_EN
                    acc_d = acc_q | (32'h8000_0000 >> cnt_q);
                    cnt_d = 5'd16;
`else
                    // Bits below the count are always zero, so padding is
                    // just a count bump to a full word.
                    cnt_d = (cnt_q != 5'd0) ? 5'd16 : 5'd0;
`endif
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_d == 5'd0) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            acc_q   <= 32'd0;
            cnt_q   <= 5'd0;
            total_q <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            done_q  <= done_d;
        end
    end

    assign code_ready_o = w_code_ready;
    assign word_out_o   = acc_q[31:16];
    assign word_valid_o = w_word_valid;
    assign flush_done_o = done_q;
    assign total_bits_o = total_q;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_bit_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cavlc_bit_packer
// Description : Self-checking bench for cavlc_bit_packer. Directed scenarios
//               plus randomized traffic checked against a bit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cavlc_bit_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] code = 16'h0;
    logic [4:0]  code_len = 5'd0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic        flush = 1'b0;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        flush_done;
    logic [31:0] total_bits;

    int checks = 0;
    int errors = 0;

    bit          mq[$];
    logic [31:0] mtotal;
    logic [15:0] fw[$];

    always #5 clk = ~clk;

    cavlc_bit_packer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .code_i       (code),
        .code_len_i   (code_len),
        .code_valid_i (code_valid),
        .code_ready_o (code_ready),
        .flush_i      (flush),
        .word_out_o   (word_out),
        .word_valid_o (word_valid),
        .word_ready_i (word_ready),
        .flush_done_o (flush_done),
        .total_bits_o (total_bits)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses the asynchronous reset mid-cycle.
    task automatic apply_reset();
        code_valid = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b1;
        rst        = 1'b1;
        #2;
        rst        = 1'b0;
        mq.delete();
        mtotal     = 32'd0;
        #1;
    endtask

    task automatic send_code(input logic [15:0] c, input logic [4:0] l);
        code_valid = 1'b1;
        code       = c;
        code_len   = l;
        #1;
        checks++;
        if (code_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: got %b expected 1", code_ready);
        end
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code_len   = 5'd0;
    endtask

    // Flush one cycle, collect words, report cycle of flush_done relative to flush.
    task automatic run_flush(output int done_at);
        fw.delete();
        done_at    = -1;
        word_ready = 1'b1;
        flush      = 1'b1;
        #1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (word_valid && word_ready) fw.push_back(word_out);
            if (flush_done) begin
                done_at = k;
                break;
            end
            checks++;
            if (code_ready !== 1'b0) begin
                errors++;
                $display("FAIL flush_code_ready: got %b expected 0 at k=%0d", code_ready, k);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (done_at < 0) begin
            errors++;
            $display("FAIL flush_timeout: got no flush_done expected pulse within 20 cycles");
        end
    endtask

    task automatic check_flush(input string nm, input int done_at, input int exp_n,
                               input logic [15:0] exp_w, input int exp_at);
        checks++;
        if (fw.size() != exp_n) begin
            errors++;
            $display("FAIL %s_count: got %0d words expected %0d", nm, fw.size(), exp_n);
        end else if (exp_n == 1) begin
            checks++;
            if (fw[0] !== exp_w) begin
                errors++;
                $display("FAIL %s_word: got %h expected %h", nm, fw[0], exp_w);
            end
        end
        checks++;
        if (done_at != exp_at) begin
            errors++;
            $display("FAIL %s_done_at: got %0d expected %0d", nm, done_at, exp_at);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_wv: got %b expected 0", word_valid); end
        checks++;
        if (word_out !== 16'h0000) begin errors++; $display("FAIL rst_wo: got %h expected 0000", word_out); end
        checks++;
        if (flush_done !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b expected 0", flush_done); end
        checks++;
        if (total_bits !== 32'd0) begin errors++; $display("FAIL rst_total: got %0d expected 0", total_bits); end
        checks++;
        if (code_ready !== 1'b1) begin errors++; $display("FAIL rst_cr: got %b expected 1", code_ready); end
        tick();
    endtask

    task automatic test_basic();
        apply_reset();
        tick();
        send_code(16'h0005, 5'd3);
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_wv0: got %b expected 0", word_valid); end
        send_code(16'h1FFF, 5'd13);
        checks++;
        if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_wv: got %b expected 1", word_valid); end
        checks++;
        if (word_out !== 16'hBFFF) begin errors++; $display("FAIL basic_wo: got %h expected BFFF", word_out); end
        checks++;
        if (total_bits !== 32'd16) begin errors++; $display("FAIL basic_total: got %0d expected 16", total_bits); end
        tick();
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_taken: got %b expected 0", word_valid); end
    endtask

    task automatic test_backpressure();
        int d;
        apply_reset();
        tick();
        word_ready = 1'b0;
        send_code(16'h000D, 5'd4);
        send_code(16'h9ABC, 5'd16);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (word_valid !== 1'b1) begin errors++; $display("FAIL bp_wv: got %b expected 1", word_valid); end
            checks++;
            if (word_out !== 16'hD9AB) begin errors++; $display("FAIL bp_wo: got %h expected D9AB", word_out); end
            checks++;
            if (code_ready !== 1'b0) begin errors++; $display("FAIL bp_cr: got %b expected 0", code_ready); end
            tick();
        end
        word_ready = 1'b1;
        #1;
        checks++;
        if (code_ready !== 1'b1) begin errors++; $display("FAIL bp_cr_release: got %b expected 1", code_ready); end
        tick();
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL bp_taken: got %b expected 0", word_valid); end
        run_flush(d);
`ifdef CAVLC_PACKER_STOPBIT_EN
        check_flush("bp_flush", d, 1, 16'hC800, 3);
`else
        check_flush("bp_flush", d, 1, 16'hC000, 3);
`endif
        tick();
    endtask

    task automatic test_straddle();
        int d;
        apply_reset();
        tick();
        send_code(16'h00AA, 5'd8);
        send_code(16'hFFFF, 5'd16);
        checks++;
        if (word_out !== 16'hAAFF || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL straddle_wo: got %h/%b expected AAFF/1", word_out, word_valid);
        end
        run_flush(d);
`ifdef CAVLC_PACKER_STOPBIT_EN
        check_flush("straddle_flush", d, 1, 16'hFF80, 3);
`else
        check_flush("straddle_flush", d, 1, 16'hFF00, 3);
`endif
        tick();
        checks++;
        if (flush_done !== 1'b0) begin errors++; $display("FAIL straddle_pulse: got %b expected 0", flush_done); end
    endtask

    task automatic test_partial_flush();
        int d;
        apply_reset();
        tick();
        send_code(16'h0016, 5'd5);
        run_flush(d);
`ifdef CAVLC_PACKER_STOPBIT_EN
        check_flush("partial", d, 1, 16'hB400, 3);
`else
        check_flush("partial", d, 1, 16'hB000, 3);
`endif
        checks++;
        if (total_bits !== 32'd5) begin errors++; $display("FAIL partial_total: got %0d expected 5", total_bits); end
        tick();
    endtask

    task automatic test_empty_and_len();
        int d;
        apply_reset();
        tick();
        run_flush(d);
`ifdef CAVLC_PACKER_STOPBIT_EN
        check_flush("empty", d, 1, 16'h8000, 3);
`else
        check_flush("empty", d, 0, 16'h0000, 3);
`endif
        tick();
        send_code(16'hFFFF, 5'd0);
        checks++;
        if (total_bits !== 32'd0 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0: got total %0d wv %b expected 0/0", total_bits, word_valid);
        end
        send_code(16'h1234, 5'd20);
        checks++;
        if (word_out !== 16'h1234 || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL len20_wo: got %h/%b expected 1234/1", word_out, word_valid);
        end
        checks++;
        if (total_bits !== 32'd16) begin errors++; $display("FAIL len20_total: got %0d expected 16", total_bits); end
        tick();
        send_code(16'hFFFF, 5'd4);
        send_code(16'h0000, 5'd12);
        checks++;
        if (word_out !== 16'hF000) begin errors++; $display("FAIL mask_wo: got %h expected F000", word_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] prev;
        apply_reset();
        tick();
        word_ready = 1'b1;
        code_valid = 1'b1;
        code_len   = 5'd16;
        prev       = 16'h0;
        for (int i = 0; i < 8; i++) begin
            code = 16'($urandom);
            #1;
            checks++;
            if (code_ready !== 1'b1) begin errors++; $display("FAIL b2b_cr: got %b expected 1", code_ready); end
            if (i > 0) begin
                checks++;
                if (word_valid !== 1'b1 || word_out !== prev) begin
                    errors++;
                    $display("FAIL b2b_wo: got %h/%b expected %h/1", word_out, word_valid, prev);
                end
            end
            prev = code;
            @(posedge clk);
            #1;
        end
        code_valid = 1'b0;
        #1;
        checks++;
        if (word_out !== prev || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last: got %h/%b expected %h/1", word_out, word_valid, prev);
        end
        checks++;
        if (total_bits !== 32'd128) begin errors++; $display("FAIL b2b_total: got %0d expected 128", total_bits); end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick();
        word_ready = 1'b0;
        send_code(16'h0ABC, 5'd12);
        apply_reset();
        checks++;
        if (word_valid !== 1'b0 || total_bits !== 32'd0 || code_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state: got wv %b total %0d cr %b expected 0/0/1",
                     word_valid, total_bits, code_ready);
        end
        tick();
        send_code(16'h5A5A, 5'd16);
        checks++;
        if (word_out !== 16'h5A5A || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_word: got %h/%b expected 5A5A/1", word_out, word_valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] ew;
        logic [15:0] c;
        logic [4:0]  l;
        bit          ev, ecr, cv, wr;
        int          el, d;
        bit          eq[$];
        apply_reset();
        tick();
        for (int i = 0; i < 3002; i++) begin
            if (i < 3000) begin
                cv = ($urandom % 4) != 0;
                wr = ($urandom % 4) != 0;
                c  = 16'($urandom);
                l  = 5'($urandom);
            end else begin
                cv = 1'b0;
                wr = 1'b1;
                c  = 16'h0;
                l  = 5'd0;
            end
            code_valid = cv;
            code       = c;
            code_len   = l;
            word_ready = wr;
            #1;
            ev  = mq.size() >= 16;
            ecr = !ev || wr;
            ew  = 16'h0;
            if (ev) for (int b = 0; b < 16; b++) ew[15-b] = mq[b];
            checks++;
            if (word_valid !== ev) begin errors++; $display("FAIL rnd_wv: got %b expected %b cyc %0d", word_valid, ev, i); end
            checks++;
            if (code_ready !== ecr) begin errors++; $display("FAIL rnd_cr: got %b expected %b cyc %0d", code_ready, ecr, i); end
            checks++;
            if (total_bits !== mtotal) begin errors++; $display("FAIL rnd_total: got %0d expected %0d cyc %0d", total_bits, mtotal, i); end
            if (ev) begin
                checks++;
                if (word_out !== ew) begin errors++; $display("FAIL rnd_wo: got %h expected %h cyc %0d", word_out, ew, i); end
            end
            if (ev && wr) repeat (16) void'(mq.pop_front());
            if (cv && ecr) begin
                el = (l > 5'd16) ? 16 : int'(l);
                for (int b = el - 1; b >= 0; b--) mq.push_back(c[b]);
                mtotal += 32'(el);
            end
            @(posedge clk);
            #1;
        end
        code_valid = 1'b0;
        eq = mq;
`ifdef CAVLC_PACKER_STOPBIT_EN
        eq.push_back(1'b1);
`endif
        ew = 16'h0;
        for (int b = 0; b < eq.size(); b++) ew[15-b] = eq[b];
        run_flush(d);
        check_flush("rnd_flush", d, (eq.size() > 0) ? 1 : 0, ew, 3);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        test_reset();
        test_basic();
        test_backpressure();
        test_straddle();
        test_partial_flush();
        test_empty_and_len();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cavlc_bit_packer.md
# cavlc_bit_packer

Bitstream writer for the CAVLC encode path, the transmit-side counterpart of the decoder's barrel shifter. It accepts variable-length codewords (1–16 bits, MSB first) from the coeff-token, level and zero encoders, concatenates them, and emits packed 16-bit words with valid/ready backpressure. A flush sequence optionally appends an RBSP stop bit, zero-pads to a word boundary and signals completion, so each block or slice ends word-aligned.

## Interface
Parameters:
- None. Widths are fixed: 16-bit output word, 16-bit maximum codeword, 32-bit accumulator.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Code  in  16  codeword, right-justified; bits above CodeLen are ignored.
- CodeLen  in  5  codeword length.
  - 0 is a no-op.
  - 17–31 are treated as 16.
- CodeValid  in  1  Code/CodeLen valid.
- CodeReady  out  1  packer can accept a code this cycle.
- Flush  in  1  align/terminate request; sampled only in RUN.
- WordOut  out  16  packed word, first bit in bit 15.
- WordValid  out  1  WordOut valid.
- WordReady  in  1  downstream accepts WordOut.
- FlushDone  out  1  one-cycle pulse; flush complete.
- TotalBits  out  32  running count of payload bits accepted (sum of effective CodeLen); wraps modulo 2^32; excludes stop and pad bits.

## Operation
- State: 32-bit accumulator Acc (MSB-aligned), BitCount 0..31, FSM {RUN, PAD, DRAIN}.
- Output side:
  - WordValid = (BitCount >= 16); WordOut = Acc[31:16].
  - Word transfer = WordValid && WordReady. On transfer, Acc shifts left by 16 (zero fill) and BitCount drops by 16.
- Input side:
  - CodeReady = (state == RUN) && (BitCount < 16 || WordReady).
  - Code transfer = CodeValid && CodeReady. The masked code is placed immediately below the existing valid bits, after any same-cycle word shift.
  - BitCount' = BitCount − 16·wordXfer + len. Maximum is 31, so there is no overflow.
- RUN:
  - If Flush = 1, go to PAD. A code transferred in the same cycle is packed first and is included in the flush.
- PAD:
  - Wait while BitCount >= 16, draining words normally.
  - When BitCount < 16:
    - Append the stop bit if configured.
    - If the resulting count is nonzero, set BitCount = 16; the low bits are already zero.
    - Go to DRAIN.
- DRAIN:
  - When BitCount == 0, go to RUN and pulse FlushDone in the next cycle, registered.
- Flush asserted outside RUN is ignored. CodeReady = 0 during PAD and DRAIN.
- Reset values: Acc = 0, BitCount = 0, state RUN, WordOut = 0x0000, WordValid = 0, FlushDone = 0, TotalBits = 0, CodeReady = 1.
- Reset mid-operation discards pending bits. No partial word is emitted.

## Timing
- A code transfer in cycle N that brings BitCount >= 16 gives WordValid = 1 in cycle N+1.
- Sustained throughput is one code per cycle while WordReady = 1.
- WordOut and WordValid are held stable while WordValid && !WordReady.
- WordReady→CodeReady is the only combinational input-to-output path.
- Flush sampled at N with BitCount < 16:
  - PAD at N+1.
  - DRAIN at N+2 (WordValid = 1 if padded).
  - FlushDone at N+3 when the final word is taken in cycle N+2; each stalled cycle delays it by one.
- Simultaneous word drain and code append in one cycle is legal and required.

## Configuration
- CAVLC_PACKER_STOPBIT_EN defined: in PAD, a single '1' bit is appended before zero padding, even when BitCount == 0. That case emits 0x8000.
- Not defined: no stop bit. Flush at BitCount == 0 emits no word, and FlushDone follows with no word transfer.

## Test plan
- Basic packing: Code=0x5/len 3, then 0x1FFF/len 13, WordReady=1 -> a single word 0xBFFF one cycle after the second accept; TotalBits = 16.
- Backpressure: 20 bits pending, WordReady=0 for 5 cycles -> WordOut stable, CodeReady=0. Then WordReady=1 -> word accepted and CodeReady=1 in the same cycle.
- Straddle: 0xAA/len 8, then 0xFFFF/len 16 -> word 0xAAFF with residual 8 bits. Flush -> 0xFF00 (macro off) or 0xFF80 (macro on), then FlushDone.
- Partial flush: 0x16/len 5, then Flush -> 0xB000 (off) or 0xB400 (on); FlushDone 3 cycles after Flush.
- Empty flush: BitCount=0, Flush -> no word and FlushDone at N+3 (off), or word 0x8000 then FlushDone (on). CodeLen=0 and CodeLen=20 (treated as 16) are also checked.
- Reset mid-operation: 12 bits pending, Reset pulse -> WordValid=0, TotalBits=0. The next 16-bit code emits exactly that code.
